// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, index/data types and the debug read FSM state.
package rv32i_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [4:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef enum logic {DBG_IDLE, DBG_BUSY} dbg_state_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one index-to-data mux with x0 zero check and optional same-cycle write forwarding.
module regfile_read_port #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter bit FWD = 1'b0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic [NREGS*XLEN-1:0] regs,
  input  logic [AW-1:0]         raddr,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);
  logic hit;
  always_comb begin
    hit = FWD && we && waddr != '0 && waddr == raddr;
    rdata = (raddr == '0) ? '0 : hit ? wdata : regs[int'(raddr)*XLEN +: XLEN];
  end
endmodule

// File: rtl/rv_regfile.sv
// rv_regfile: NREGS x XLEN register file, NRP combinational read ports, x0 hardwired, registered debug read.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module rv_regfile
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                dbg_req,
  input  logic [AW-1:0]       dbg_addr,
  output logic                dbg_ack,
  output logic [XLEN-1:0]     dbg_data
);
`ifdef REGFILE_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic [NREGS*XLEN-1:0] regs_flat;
  logic wr_en;
  logic dbg_start;
  logic [XLEN-1:0] dbg_rd;
  dbg_state_t dbg_state_q, dbg_state_d;
  logic [XLEN-1:0] dbg_data_q, dbg_data_d;
  assign wr_en = we & ~rst;
  always_comb begin
    regs_flat[XLEN-1:0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = (wr_en && waddr == AW'(i)) ? wdata : regs_q[i];
      regs_flat[i*XLEN +: XLEN] = regs_q[i];
    end
  end
  for (genvar p = 0; p < NRP; p++) begin : g_rp
    regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .FWD(FWD)) u_rp (
      .regs(regs_flat), .raddr(raddr[p*AW +: AW]), .we(wr_en), .waddr(waddr),
      .wdata(wdata), .rdata(rdata[p*XLEN +: XLEN])
    );
  end
  // Debug capture always sees a write committing on the same edge.
  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .FWD(1'b1)) u_dbg_rp (
    .regs(regs_flat), .raddr(dbg_addr), .we(wr_en), .waddr(waddr),
    .wdata(wdata), .rdata(dbg_rd)
  );
  always_comb begin
    dbg_start = dbg_state_q == DBG_IDLE && dbg_req;
    dbg_state_d = dbg_start ? DBG_BUSY : DBG_IDLE;
    dbg_data_d = dbg_start ? dbg_rd : dbg_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_state_q <= DBG_IDLE;
      dbg_data_q <= '0;
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      dbg_state_q <= dbg_state_d;
      dbg_data_q <= dbg_data_d;
      regs_q <= regs_d;
    end
  end
  assign dbg_ack = dbg_state_q == DBG_BUSY;
  assign dbg_data = dbg_data_q;
endmodule

// File: tb/tb_rv_regfile.sv
// tb_rv_regfile: directed stimulus pushes expected outputs tagged with a cycle; a negedge monitor pops and compares.
module tb_rv_regfile;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] raddr;
  logic [63:0] rdata;
  logic we;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic dbg_req;
  logic [4:0] dbg_addr;
  logic dbg_ack;
  logic [31:0] dbg_data;

  typedef struct {
    int cyc;
    int kind;
    int port;
    logic [31:0] exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  rv_regfile dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .we(we), .waddr(waddr),
    .wdata(wdata), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input int p, input logic [31:0] e, input string n);
    sb.push_back('{cyc, 0, p, e, n});
  endtask

  task automatic exp_dbg(input logic a, input logic [31:0] d, input string n);
    sb.push_back('{cyc, 1, 0, {31'b0, a}, {n, "_ack"}});
    sb.push_back('{cyc, 2, 0, d, {n, "_data"}});
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    bit ack_seen;
    if (mon_en) begin
      ack_seen = 1'b0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act = (e.kind == 0) ? rdata[e.port*32 +: 32] : (e.kind == 1) ? {31'b0, dbg_ack} : dbg_data;
        if (e.kind == 1) ack_seen = 1'b1;
        checks++;
        if (act !== e.exp || e.cyc != cyc) begin
          failures++;
          $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", e.name, act, e.exp, cyc, e.cyc);
        end
      end
      if (!ack_seen) begin
        checks++;
        if (dbg_ack !== 1'b0) begin
          failures++;
          $display("FAIL spurious_ack: got %b expected 0 (cycle %0d)", dbg_ack, cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; dbg_req = 1'b0; dbg_addr = '0;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    exp_dbg(1'b0, 32'h0, "reset_init");
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    tick();
    we = 1'b0;
    exp_rd(0, 32'hDEADBEEF, "x5_before_reset");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd(0, 32'h0, "x5_after_reset");
    exp_dbg(1'b0, 32'h0, "reset");
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    exp_rd(0, 32'h0, "x0_write_cycle_p0");
    exp_rd(1, 32'h0, "x0_write_cycle_p1");
    tick();
    we = 1'b0;
    exp_rd(0, 32'h0, "x0_after_p0");
    exp_rd(1, 32'h0, "x0_after_p1");
    we = 1'b1; waddr = 5'd1; wdata = 32'h11;
    tick();
    waddr = 5'd2; wdata = 32'h22;
    tick();
    waddr = 5'd31; wdata = 32'h80000000;
    tick();
    we = 1'b0; raddr = {5'd2, 5'd31};
    exp_rd(0, 32'h80000000, "mp_x31");
    exp_rd(1, 32'h22, "mp_x2");
    tick();
    raddr = {5'd1, 5'd1};
    exp_rd(0, 32'h11, "mp_x1_p0");
    exp_rd(1, 32'h11, "mp_x1_p1");
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234; raddr = {5'd0, 5'd7};
`ifdef REGFILE_BYPASS_EN
    exp_rd(0, 32'h1234, "x7_fwd");
`else
    exp_rd(0, 32'h0, "x7_old");
`endif
    tick();
    we = 1'b0;
    exp_rd(0, 32'h1234, "x7_next");
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE;
    tick();
    we = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd9;
    exp_dbg(1'b0, 32'h0, "dbg_req_cycle");
    tick();
    dbg_req = 1'b0;
    exp_dbg(1'b1, 32'hCAFE, "dbg_x9");
    tick();
    exp_dbg(1'b0, 32'hCAFE, "dbg_hold");
    dbg_req = 1'b1; dbg_addr = 5'd10; we = 1'b1; waddr = 5'd10; wdata = 32'hA5A5;
    tick();
    dbg_req = 1'b0; we = 1'b0;
    exp_dbg(1'b1, 32'hA5A5, "dbg_same_edge_write");
    tick();
    dbg_req = 1'b1; dbg_addr = 5'd9;
    tick();
    exp_dbg(1'b1, 32'hCAFE, "dbg_held_busy");
    tick();
    dbg_req = 1'b0;
    exp_dbg(1'b0, 32'hCAFE, "dbg_no_extra_ack");
    tick();
    dbg_req = 1'b1; dbg_addr = 5'd0;
    tick();
    dbg_req = 1'b0;
    exp_dbg(1'b1, 32'h0, "dbg_x0");
    tick();
    dbg_req = 1'b1; dbg_addr = 5'd9;
    tick();
    dbg_req = 1'b0; rst = 1'b1;
    exp_dbg(1'b1, 32'hCAFE, "dbg_before_rst");
    tick();
    rst = 1'b0; raddr = {5'd10, 5'd9};
    exp_dbg(1'b0, 32'h0, "dbg_rst_busy");
    exp_rd(0, 32'h0, "x9_after_rst");
    exp_rd(1, 32'h0, "x10_after_rst");
    tick();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
